// File: rtl/gpr_wb_arb_if.sv
// Bundle of the three GPR write producers, the scoreboard allocate port,
// the busy scoreboard and the registered GPR write port.
//   master : the producers / issue logic / GPR file side
//   slave  : the arbiter (gpr_wb_arb)
// Parameter DW sets the rd data width.
interface gpr_wb_arb_if #(
  parameter int unsigned DW = 64
);

  // Port 0: main-pipeline WB
  logic          p0_valid;
  logic          p0_ready;
  logic [4:0]    p0_idx;
  logic [DW-1:0] p0_data;

  // Port 1: FPU/VPU integer-result return
  logic          p1_valid;
  logic          p1_ready;
  logic [4:0]    p1_idx;
  logic [DW-1:0] p1_data;

  // Port 2: load return
  logic          p2_valid;
  logic          p2_ready;
  logic [4:0]    p2_idx;
  logic [DW-1:0] p2_data;

  // Long-latency destination allocation and scoreboard
  logic          alloc_en;
  logic [4:0]    alloc_idx;
  logic [31:0]   busy;

  // GPR write port
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [DW-1:0] wr_data;

  modport master (
    output p0_valid, p0_idx, p0_data,
    output p1_valid, p1_idx, p1_data,
    output p2_valid, p2_idx, p2_data,
    output alloc_en, alloc_idx,
    input  p0_ready, p1_ready, p2_ready,
    input  busy, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  p0_valid, p0_idx, p0_data,
    input  p1_valid, p1_idx, p1_data,
    input  p2_valid, p2_idx, p2_data,
    input  alloc_en, alloc_idx,
    output p0_ready, p1_ready, p2_ready,
    output busy, wr_en, wr_idx, wr_data
  );

endinterface

// File: rtl/gpr_wb_arb.sv
// GPR write-port arbiter. Port 0 (WB) has priority; ports 1 (FPU/VPU) and
// 2 (load return) share the remaining slots round-robin. The winner is
// registered into a one-stage GPR write output. A 32-bit busy scoreboard
// tracks destinations with outstanding port 1/2 writes.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - gpr_wb_arb_if.slave: p0/p1/p2 valid/ready/idx/data, alloc_en/
//          alloc_idx, busy, wr_en/wr_idx/wr_data
//
// Optional feature macro: GPR_WB_STARVE_GUARD_EN
//   Defined   : a port 1/2 request losing STARVE_MAX consecutive cycles to
//               port 0 is forced through on the next cycle.
//   Undefined : strict port 0 priority, no starvation counter.
module gpr_wb_arb #(
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic           clk,
  input  logic           rst,
  gpr_wb_arb_if.slave    bus
);

  // Elaboration-time sanity check on the starvation threshold
  if (STARVE_MAX == 0) begin : g_cfg_check
    $error("gpr_wb_arb: STARVE_MAX must be at least 1");
  end

  // Round-robin pointer encoding: which of ports 1/2 is favoured
  localparam logic RR_P1 = 1'b0;
  localparam logic RR_P2 = 1'b1;

  logic          rr_ptr;
  logic          req12;
  logic          pick2;
  logic          p0_ok;
  logic          gnt0;
  logic          gnt12;
  logic          gnt1;
  logic          gnt2;
  logic          any_gnt;
  logic [4:0]    sel_idx;
  logic [DW-1:0] sel_data;

  logic          wr_en_q;
  logic [4:0]    wr_idx_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_src12_q;
  logic [31:0]   busy_q;
  logic [31:0]   busy_nxt;

  assign req12 = bus.p1_valid | bus.p2_valid;

  // Port 2 wins the 1/2 slot if it is the only requester or the pointer favours it
  assign pick2 = bus.p2_valid & (~bus.p1_valid | (rr_ptr == RR_P2));

`ifdef GPR_WB_STARVE_GUARD_EN
  localparam int unsigned CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          force12;

  // Threshold reached with a 1/2 request still waiting: port 0 yields
  assign force12 = req12 & (starve_cnt == CW'(STARVE_MAX));
  assign p0_ok   = ~force12;

  // Consecutive cycles a waiting port 1/2 request has lost to port 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (gnt12 || !req12) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign p0_ok = 1'b1;
`endif

  // Grant decode; nothing is granted while reset is asserted
  assign gnt0    = rst & p0_ok & bus.p0_valid;
  assign gnt12   = rst & req12 & ~(p0_ok & bus.p0_valid);
  assign gnt1    = gnt12 & ~pick2;
  assign gnt2    = gnt12 & pick2;
  assign any_gnt = gnt0 | gnt12;

  assign bus.p0_ready = rst & p0_ok;
  assign bus.p1_ready = gnt1;
  assign bus.p2_ready = gnt2;

  // Winner payload mux
  always_comb begin
    sel_idx  = bus.p0_idx;
    sel_data = bus.p0_data;
    if (gnt1) begin
      sel_idx  = bus.p1_idx;
      sel_data = bus.p1_data;
    end else if (gnt2) begin
      sel_idx  = bus.p2_idx;
      sel_data = bus.p2_data;
    end
  end

  // Round-robin pointer moves to the other port after a port 1/2 grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= RR_P1;
    end else if (gnt12) begin
      rr_ptr <= pick2 ? RR_P1 : RR_P2;
    end
  end

  // Output stage; x0 writes are accepted but never enable the GPR write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr_src12_q <= 1'b0;
    end else begin
      wr_en_q <= any_gnt & (sel_idx != 5'd0);
      if (any_gnt) begin
        wr_idx_q   <= sel_idx;
        wr_data_q  <= sel_data;
        wr_src12_q <= gnt12;
      end
    end
  end

  // Scoreboard update: clear on a completing port 1/2 write, set on alloc (set wins)
  always_comb begin
    busy_nxt = busy_q;
    if (wr_en_q && wr_src12_q) begin
      busy_nxt[wr_idx_q] = 1'b0;
    end
    if (bus.alloc_en && (bus.alloc_idx != 5'd0)) begin
      busy_nxt[bus.alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed self-checking bench for gpr_wb_arb: reset state, port 0 writes,
// x0 suppression, port 1/2 round-robin, scoreboard set/clear/priority,
// starvation behaviour (both builds) and asynchronous reset mid-stream.
module tb_gpr_wb_arb;

  localparam int unsigned DW = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gpr_wb_arb_if #(.DW(DW)) bus ();

  gpr_wb_arb #(.DW(DW), .STARVE_MAX(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_valid  = 1'b0; bus.p0_idx = '0; bus.p0_data = '0;
    bus.p1_valid  = 1'b0; bus.p1_idx = '0; bus.p1_data = '0;
    bus.p2_valid  = 1'b0; bus.p2_idx = '0; bus.p2_data = '0;
    bus.alloc_en  = 1'b0; bus.alloc_idx = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en);
    end
    n_checks++;
    if (bus.busy !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy);
    end
    n_checks++;
    if (bus.p0_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_p0_ready: got %b want 0", bus.p0_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.wr_en, bus.busy} !== 33'h0) begin
      n_fail++; $display("FAIL idle_out: got wr_en=%b busy=%h want 0/0", bus.wr_en, bus.busy);
    end
    n_checks++;
    if ({bus.p0_ready, bus.p1_ready, bus.p2_ready} !== 3'b100) begin
      n_fail++; $display("FAIL idle_ready: got %b want 100",
                         {bus.p0_ready, bus.p1_ready, bus.p2_ready});
    end
  endtask

  task automatic test_p0_write();
    bus.p0_valid = 1'b1; bus.p0_idx = 5'd5; bus.p0_data = 64'hA5;
    #1;
    n_checks++;
    if (bus.p0_ready !== 1'b1) begin
      n_fail++; $display("FAIL p0_ready: got %b want 1", bus.p0_ready);
    end
    step();
    bus.p0_valid = 1'b0;
    n_checks++;
    if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd5, 64'hA5}) begin
      n_fail++; $display("FAIL p0_write: got en=%b idx=%0d data=%h want 1/5/a5",
                         bus.wr_en, bus.wr_idx, bus.wr_data);
    end
    // x0 write is accepted but must not enable the GPR write
    bus.p0_valid = 1'b1; bus.p0_idx = 5'd0; bus.p0_data = 64'h33;
    #1;
    n_checks++;
    if (bus.p0_ready !== 1'b1) begin
      n_fail++; $display("FAIL p0_x0_ready: got %b want 1", bus.p0_ready);
    end
    step();
    bus.p0_valid = 1'b0;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL p0_x0_wr_en: got %b want 0", bus.wr_en);
    end
    step();
    n_checks++;
    if (bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_x0: got %b want 0", bus.wr_en);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_idx;
    logic [63:0] exp_data;
    logic [1:0]  exp_rdy;
    bus.p1_valid = 1'b1; bus.p1_idx = 5'd3; bus.p1_data = 64'h111;
    bus.p2_valid = 1'b1; bus.p2_idx = 5'd4; bus.p2_data = 64'h222;
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_idx  = (i % 2 == 0) ? 5'd3 : 5'd4;
      exp_data = (i % 2 == 0) ? 64'h111 : 64'h222;
      #1;
      n_checks++;
      if ({bus.p1_ready, bus.p2_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i,
                           {bus.p1_ready, bus.p2_ready}, exp_rdy);
      end
      step();
      n_checks++;
      if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, exp_idx, exp_data}) begin
        n_fail++; $display("FAIL rr_write[%0d]: got en=%b idx=%0d data=%h want 1/%0d/%h",
                           i, bus.wr_en, bus.wr_idx, bus.wr_data, exp_idx, exp_data);
      end
    end
    // Pointer favours port 1 now, but a lone port 2 request still wins
    bus.p1_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.p1_ready, bus.p2_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rr_lone_p2: got %b want 01", {bus.p1_ready, bus.p2_ready});
    end
    step();
    bus.p2_valid = 1'b0;
    step();
  endtask

  task automatic test_scoreboard();
    // Allocate x7, then retire it through port 2
    bus.alloc_en = 1'b1; bus.alloc_idx = 5'd7;
    step();
    bus.alloc_en = 1'b0;
    n_checks++;
    if (bus.busy !== 32'h80) begin
      n_fail++; $display("FAIL sb_alloc: got %h want 00000080", bus.busy);
    end
    bus.p2_valid = 1'b1; bus.p2_idx = 5'd7; bus.p2_data = 64'h77;
    step();
    bus.p2_valid = 1'b0;
    n_checks++;
    if ({bus.wr_en, bus.wr_idx, bus.busy} !== {1'b1, 5'd7, 32'h80}) begin
      n_fail++; $display("FAIL sb_pending: got en=%b idx=%0d busy=%h want 1/7/00000080",
                         bus.wr_en, bus.wr_idx, bus.busy);
    end
    step();
    n_checks++;
    if (bus.busy !== 32'h0) begin
      n_fail++; $display("FAIL sb_clear: got %h want 0", bus.busy);
    end
    // Re-allocation at the clearing edge wins
    bus.alloc_en = 1'b1; bus.alloc_idx = 5'd7;
    step();
    bus.alloc_en = 1'b0;
    bus.p1_valid = 1'b1; bus.p1_idx = 5'd7; bus.p1_data = 64'h78;
    step();
    bus.p1_valid = 1'b0;
    bus.alloc_en = 1'b1; bus.alloc_idx = 5'd7;
    step();
    bus.alloc_en = 1'b0;
    n_checks++;
    if (bus.busy !== 32'h80) begin
      n_fail++; $display("FAIL sb_set_wins: got %h want 00000080", bus.busy);
    end
    // Port 0 write to a busy register must not clear it; x0 alloc ignored
    bus.p0_valid = 1'b1; bus.p0_idx = 5'd7; bus.p0_data = 64'h99;
    bus.alloc_en = 1'b1; bus.alloc_idx = 5'd0;
    step();
    bus.p0_valid = 1'b0;
    bus.alloc_en = 1'b0;
    step();
    n_checks++;
    if (bus.busy !== 32'h80) begin
      n_fail++; $display("FAIL sb_p0_keeps: got %h want 00000080", bus.busy);
    end
    n_checks++;
    if (bus.wr_data !== 64'h99) begin
      n_fail++; $display("FAIL sb_p0_data: got %h want 99", bus.wr_data);
    end
  endtask

  task automatic test_starve();
    logic [1:0] exp_rdy;
    bus.p0_valid = 1'b1; bus.p0_idx = 5'd9;  bus.p0_data = 64'h9;
    bus.p1_valid = 1'b1; bus.p1_idx = 5'd10; bus.p1_data = 64'hA;
    for (int c = 1; c <= 10; c++) begin
`ifdef GPR_WB_STARVE_GUARD_EN
      exp_rdy = (c == 8) ? 2'b01 : 2'b10;
`else
      exp_rdy = 2'b10;
`endif
      #1;
      n_checks++;
      if ({bus.p0_ready, bus.p1_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL starve_ready[cycle %0d]: got p0/p1=%b want %b", c,
                           {bus.p0_ready, bus.p1_ready}, exp_rdy);
      end
      step();
      if (exp_rdy == 2'b01) begin
        bus.p1_valid = 1'b0;
        n_checks++;
        if (bus.wr_idx !== 5'd10) begin
          n_fail++; $display("FAIL starve_write: got idx=%0d want 10", bus.wr_idx);
        end
      end
    end
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bus.alloc_en = 1'b1; bus.alloc_idx = 5'd12;
    bus.p0_valid = 1'b1; bus.p0_idx = 5'd12; bus.p0_data = 64'hDEAD;
    step();
    idle_inputs();
    n_checks++;
    if ({bus.wr_en, bus.wr_idx} !== {1'b1, 5'd12}) begin
      n_fail++; $display("FAIL arst_pre: got en=%b idx=%0d want 1/12", bus.wr_en, bus.wr_idx);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.wr_en, bus.wr_idx, bus.wr_data, bus.busy} !== '0) begin
      n_fail++; $display("FAIL arst_clear: got en=%b idx=%0d data=%h busy=%h want all 0",
                         bus.wr_en, bus.wr_idx, bus.wr_data, bus.busy);
    end
    bus.p1_valid = 1'b1; bus.p1_idx = 5'd1;
    bus.p2_valid = 1'b1; bus.p2_idx = 5'd2;
    #1;
    n_checks++;
    if ({bus.p0_ready, bus.p1_ready, bus.p2_ready} !== 3'b000) begin
      n_fail++; $display("FAIL arst_ready: got %b want 000",
                         {bus.p0_ready, bus.p1_ready, bus.p2_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    // Pointer is back on port 1 after reset
    n_checks++;
    if ({bus.p1_ready, bus.p2_ready} !== 2'b10) begin
      n_fail++; $display("FAIL arst_rr: got %b want 10", {bus.p1_ready, bus.p2_ready});
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_p0_write();
    test_round_robin();
    test_scoreboard();
    test_starve();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
